// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding word fetch, a one-entry holding slot for decode,
// and redirect handling that lets an in-flight access finish before retargeting.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | post-reset bubble, no request; late acks are ignored here
// FETCH | request outstanding at pc
// DROP  | request outstanding for a redirected-away address; data is discarded
// VALID | instruction held for decode, no request
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;

    logic [31:0] tgt_aligned;
    logic [31:0] pc_plus4;
    logic [31:0] drop_next_pc;

    assign tgt_aligned  = branch_target & ~32'h0000_0003;
    assign pc_plus4     = pc_q + 32'd4;
    // A branch arriving together with the ack overrides the redirect saved earlier.
    assign drop_next_pc = branch_taken ? tgt_aligned : redir_pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;

        case (state_q)
            IDLE: begin
                state_d     = FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end
            FETCH: begin
                if (imem_ack && !branch_taken) begin
                    id_instr_d    = imem_rdata;
                    id_pc_plus4_d = pc_plus4;
                    pc_d          = pc_plus4;
                    id_valid_d    = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = VALID;
                end else if (imem_ack) begin
                    pc_d        = tgt_aligned;
                    imem_addr_d = tgt_aligned;
                end else if (branch_taken) begin
                    // Bus must not see the address change mid-request.
                    redir_pc_d = tgt_aligned;
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_d        = drop_next_pc;
                    imem_addr_d = drop_next_pc;
                    state_d     = FETCH;
                end else if (branch_taken) begin
                    redir_pc_d = tgt_aligned;
                end
            end
            VALID: begin
                if (branch_taken) begin
                    pc_d        = tgt_aligned;
                    imem_addr_d = tgt_aligned;
                    imem_req_d  = 1'b1;
                    id_valid_d  = 1'b0;
                    state_d     = FETCH;
                end else if (id_ready) begin
                    imem_addr_d = pc_q;
                    imem_req_d  = 1'b1;
                    id_valid_d  = 1'b0;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            redir_pc_q    <= 32'h0;
            id_instr_q    <= 32'h0;
            id_pc_plus4_q <= 32'h0;
            id_valid_q    <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_opcode   = id_instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, every cycle compared
// against a transaction-level reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: flags describing what the fetcher is doing, not an encoded state.
    logic        m_after_reset;
    logic        m_req;
    logic        m_hold;
    logic        m_discard;
    logic [31:0] m_addr;
    logic [31:0] m_next_pc;
    logic [31:0] m_redir;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4),
        .id_opcode    (id_opcode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic ack, input logic [31:0] rd,
                                input logic br, input logic [31:0] tg, input logic rdy);
        logic [31:0] t;
        t = {tg[31:2], 2'b00};
        if (r) begin
            m_after_reset = 1'b1;
            m_req         = 1'b0;
            m_hold        = 1'b0;
            m_discard     = 1'b0;
            m_addr        = RESET_PC;
            m_next_pc     = RESET_PC;
            m_redir       = 32'h0;
            m_instr       = 32'h0;
            m_pcp4        = 32'h0;
        end else if (m_after_reset) begin
            m_after_reset = 1'b0;
            m_req         = 1'b1;
            m_addr        = m_next_pc;
        end else if (m_hold) begin
            if (br || rdy) begin
                if (br) m_next_pc = t;
                m_hold = 1'b0;
                m_req  = 1'b1;
                m_addr = m_next_pc;
            end
        end else if (m_discard) begin
            if (ack) begin
                m_next_pc = br ? t : m_redir;
                m_addr    = m_next_pc;
                m_discard = 1'b0;
            end else if (br) begin
                m_redir = t;
            end
        end else if (ack && !br) begin
            m_instr   = rd;
            m_pcp4    = m_addr + 32'd4;
            m_next_pc = m_addr + 32'd4;
            m_hold    = 1'b1;
            m_req     = 1'b0;
        end else if (ack) begin
            m_next_pc = t;
            m_addr    = t;
        end else if (br) begin
            m_redir   = t;
            m_discard = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic ack, input logic [31:0] rd,
                        input logic br, input logic [31:0] tg, input logic rdy);
        rst           = r;
        imem_ack      = ack;
        imem_rdata    = rd;
        branch_taken  = br;
        branch_target = tg;
        id_ready      = rdy;
        @(posedge clk);
        model_update(r, ack, rd, br, tg, rdy);
        #1;
        chk("req", 32'(imem_req), 32'(m_req));
        chk("valid", 32'(id_valid), 32'(m_hold));
        if (m_req) chk("addr", imem_addr, m_addr);
        if (m_hold) begin
            chk("instr", id_instr, m_instr);
            chk("pcp4", id_pc_plus4, m_pcp4);
            chk("opcode", 32'(id_opcode), 32'(m_instr[31:26]));
        end
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        branch_taken = 1'b0; branch_target = 32'h0; id_ready = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 32'hDEAD_BEEF, 1, 32'h80, 1);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pcp4", id_pc_plus4, 32'h0);

        // Zero-wait sequential fetch
        step(0, 0, 0, 0, 0, 0);
        chk("seq_addr0", imem_addr, 32'h0);
        step(0, 1, 32'h8C01_0004, 0, 0, 0);
        chk("seq_pcp4_4", id_pc_plus4, 32'h4);
        chk("seq_opcode", 32'(id_opcode), 32'h23);
        step(0, 1, 32'h8C01_0004, 0, 0, 1);
        chk("seq_addr4", imem_addr, 32'h4);
        step(0, 1, 32'h8C01_0004, 0, 0, 0);
        chk("seq_pcp4_8", id_pc_plus4, 32'h8);
        step(0, 1, 32'h8C01_0004, 0, 0, 1);
        chk("seq_addr8", imem_addr, 32'h8);
        step(0, 1, 32'h1234_5678, 0, 0, 0);
        chk("seq_pcp4_12", id_pc_plus4, 32'hC);

        // Decode stall: slot held, no request
        held = id_instr;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'hFFFF_0000, 0, 0, 0);
            chk("stall_valid", 32'(id_valid), 32'h1);
            chk("stall_instr", id_instr, held);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("stall_next_addr", imem_addr, 32'hC);

        // Ack together with a branch retargets, then a redirect under a slow ack
        step(0, 1, 32'hAAAA_AAAA, 1, 32'h10, 0);
        chk("redir_addr10", imem_addr, 32'h10);
        step(0, 0, 0, 1, 32'h40, 0);
        chk("drop_hold1", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);
        chk("drop_hold2", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 0);
        chk("drop_hold3", imem_addr, 32'h10);
        step(0, 1, 32'hBAD0_0010, 0, 0, 1);
        chk("drop_valid", 32'(id_valid), 32'h0);
        chk("drop_next_addr", imem_addr, 32'h40);
        step(0, 1, 32'h0440_0000, 0, 0, 0);
        chk("after_drop_pcp4", id_pc_plus4, 32'h44);

        // Squash with unaligned target while decode is ready
        step(0, 0, 0, 1, 32'h103, 1);
        chk("squash_valid", 32'(id_valid), 32'h0);
        chk("squash_addr", imem_addr, 32'h100);

        // Branch in the same cycle as the DROP ack wins over the saved redirect
        step(0, 0, 0, 1, 32'h200, 0);
        step(0, 1, 32'h0, 1, 32'h302, 0);
        chk("drop_branch_wins", imem_addr, 32'h300);

        // Address wrap
        step(0, 1, 32'h0, 1, 32'hFFFF_FFFC, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 32'h5555_0001, 0, 0, 0);
        chk("wrap_pcp4", id_pc_plus4, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset while a request is outstanding; late ack lands in IDLE
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_req", 32'(imem_req), 32'h0);
        step(0, 1, 32'h7777_7777, 1, 32'h500, 1);
        chk("late_ack_valid", 32'(id_valid), 32'h0);
        chk("late_ack_addr", imem_addr, RESET_PC);
        step(0, 0, 0, 0, 0, 0);
        chk("late_ack_valid2", 32'(id_valid), 32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic        r, a, b, y;
            logic [31:0] d, t;
            r = ($urandom_range(0, 59) == 0);
            a = ($urandom_range(0, 2) != 0);
            b = ($urandom_range(0, 5) == 0);
            y = ($urandom_range(0, 1) == 1);
            d = $urandom;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
            step(r, a, d, b, t, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset; low two bits SHALL be zero.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory returns data this cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 branch_taken  input  1  redirect request from the execute stage.
REQ-010 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-011 id_ready  input  1  decode stage accepts the held instruction.
REQ-012 id_valid  output  1  id_instr/id_pc_plus4 hold a live instruction.
REQ-013 id_instr  output  32  fetched instruction word.
REQ-014 id_pc_plus4  output  32  fetch address + 4 of id_instr.
REQ-015 id_opcode  output  6  id_instr[31:26], combinational; drives the control unit's opcode input.

Function
REQ-016 States SHALL be IDLE, FETCH, DROP and VALID, held in one registered state variable.
REQ-017 IDLE: imem_req=0, id_valid=0; next state SHALL be FETCH unconditionally.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ack with branch_taken=0, the block SHALL latch id_instr=imem_rdata, id_pc_plus4=pc+4, set pc=pc+4 and go to VALID.
REQ-019 FETCH with imem_ack=1 and branch_taken=1: the block SHALL discard imem_rdata, set pc=branch_target and remain in FETCH.
REQ-020 FETCH with imem_ack=0 and branch_taken=1: the block SHALL save branch_target in redir_pc and go to DROP; imem_req and imem_addr SHALL stay unchanged.
REQ-021 While imem_req=1 without imem_ack, imem_addr SHALL be held stable every cycle.
REQ-022 DROP: imem_req=1 with the old address; on imem_ack, data SHALL be discarded, pc=redir_pc, next state FETCH.
REQ-023 DROP: a further branch_taken SHALL overwrite redir_pc; a branch in the same cycle as the ack SHALL take precedence over the saved value.
REQ-024 VALID: id_valid=1, imem_req=0; id_instr and id_pc_plus4 SHALL be held stable until consumed or squashed.
REQ-025 VALID with branch_taken=1: the block SHALL squash the instruction regardless of id_ready, set pc=branch_target, go to FETCH, and drive id_valid=0 next cycle.
REQ-026 VALID with id_ready=1 and branch_taken=0: the instruction SHALL be consumed, next state FETCH, id_valid=0 next cycle.
REQ-027 Minimum throughput SHALL be one instruction per two cycles (zero-wait memory); fetch latency SHALL be request cycle to id_valid = 1 cycle after ack.
REQ-028 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-029 branch_target[1:0] SHALL be forced to 2'b00 when loaded into pc or redir_pc.
REQ-030 branch_taken in IDLE SHALL be ignored.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, pc=RESET_PC, redir_pc=0, id_valid=0, id_instr=0, id_pc_plus4=0, imem_req=0, imem_addr=RESET_PC.
REQ-032 Reset mid-request SHALL abandon the outstanding access; a late imem_ack arriving in IDLE SHALL have no effect.
REQ-033 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Reset release, memory acks every request cycle with imem_rdata=32'h8C01_0004 -> imem_addr 0,4,8 on successive fetches; id_opcode=6'b100011; id_pc_plus4=4,8,12.
REQ-035 id_ready=0 for 5 cycles in VALID -> id_valid, id_instr and imem_req=0 stable throughout; fetch of pc+4 starts the cycle after id_ready=1.
REQ-036 Ack delayed 3 cycles at addr 0x10 with branch_taken=1, target 0x40 on the 1st wait cycle -> imem_addr holds 0x10 until ack; data discarded; next imem_addr=0x40; id_valid never asserted for 0x10.
REQ-037 branch_taken=1 with target 0x103 while VALID and id_ready=1 -> instruction squashed; next imem_addr=0x100.
REQ-038 pc=0xFFFF_FFFC fetch acked -> id_pc_plus4=0; next imem_addr=0.
REQ-039 rst asserted during FETCH with ack pending, ack arrives next cycle -> id_valid stays 0; first post-reset imem_addr=RESET_PC.
